// File: rtl/barcode_reader.sv
// barcode_reader: decodes a serial barcode strip (start bit + 8 data bits,
// MSB first, pulse-width encoded) into an 8-bit station ID, and publishes it
// through an ID / ID_vld / clr_ID_vld handshake.
module barcode_reader #(
  parameter int TMR_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [2:0] {IDLE, START, WAIT_FALL, BIT, DONE} state_t;

  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  state_t           r_state, w_nxt;
  logic [2:0]       r_sync;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] r_period;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_id;
  logic             r_id_vld;

  logic w_bc_s, w_bc_d, w_fall, w_rise;
  logic w_tmo, w_smp, w_pub, w_latch_per;

  // BC is asynchronous: two flops to synchronise, a third for edge detection
  assign w_bc_s = r_sync[1];
  assign w_bc_d = r_sync[2];
  assign w_fall = w_bc_d & ~w_bc_s;
  assign w_rise = ~w_bc_d & w_bc_s;

  // A saturated timer outside IDLE means the strip stalled; abandon the frame
  assign w_tmo       = (r_state != IDLE) && (&r_tmr);
  assign w_smp       = (r_state == BIT) && (r_tmr == r_period) && !w_tmo;
  assign w_latch_per = (r_state == START) && w_rise && !w_tmo;
  assign w_pub       = (r_state == DONE) && (r_shift[7:6] == 2'b00);

  // Synchroniser presets to 1 so reset looks like an idle (high) strip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], BC};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:      if (w_fall) w_nxt = START;
      START:     if (w_tmo) w_nxt = IDLE;
                 else if (w_rise) w_nxt = WAIT_FALL;
      WAIT_FALL: if (w_tmo) w_nxt = IDLE;
                 else if (w_fall) w_nxt = BIT;
      // falls arriving before the sample point are deliberately ignored
      BIT:       if (w_tmo) w_nxt = IDLE;
                 else if (w_smp) w_nxt = (r_bit_cnt == 3'd7) ? DONE : WAIT_FALL;
      DONE:      w_nxt = IDLE;
      default:   w_nxt = IDLE;
    endcase
  end

  // Timer restarts on every state change so each phase is measured from its own start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_tmr <= '0;
    else if (w_nxt != r_state)  r_tmr <= '0;
    else                        r_tmr <= r_tmr + TMR_ONE;
  end

  // Start-bit low time becomes the sample point for every data cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
    end else if (w_latch_per) begin
      r_period  <= r_tmr;
      r_bit_cnt <= 3'd0;
    end else if (w_smp) begin
      r_shift   <= {r_shift[6:0], w_bc_s};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Publish wins over a simultaneous acknowledge so a fresh ID is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id     <= 8'h00;
      r_id_vld <= 1'b0;
    end else if (w_pub) begin
      r_id     <= r_shift;
      r_id_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      r_id_vld <= 1'b0;
    end
  end

  assign ID     = r_id;
  assign ID_vld = r_id_vld;

endmodule

// File: tb/tb_barcode_reader.sv
// tb_barcode_reader: directed test of barcode_reader. Two instances: the
// default 22-bit timer and an 8-bit timer variant for timeout coverage.
module tb_barcode_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bc = 1'b1, bc8 = 1'b1;
  logic       clr = 1'b0, clr8 = 1'b0;
  logic [7:0] id, id8;
  logic       vld, vld8;

  int n_chk = 0;
  int n_err = 0;

  barcode_reader u_dut (
    .clk(clk), .rst_n(rst_n), .BC(bc), .clr_ID_vld(clr), .ID(id), .ID_vld(vld)
  );

  barcode_reader #(.TMR_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .BC(bc8), .clr_ID_vld(clr8), .ID(id8), .ID_vld(vld8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n clocks, then step just past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic sel, input logic v);
    if (sel) bc8 = v;
    else     bc  = v;
  endtask

  // start bit (low 2u, cell 4u) then the first nbits data bits, MSB first;
  // a 1 is low for u, a 0 is low for 3u, every cell is 4u
  task automatic send(input logic sel, input logic [7:0] d, input int nbits, input int u);
    drv(sel, 1'b0); tick(2*u);
    drv(sel, 1'b1); tick(2*u);
    for (int i = 0; i < nbits; i++) begin
      drv(sel, 1'b0); tick(d[7-i] ? u : 3*u);
      drv(sel, 1'b1); tick(d[7-i] ? 3*u : u);
    end
  endtask

  task automatic frame(input logic sel, input logic [7:0] d, input int u);
    send(sel, d, 8, u);
    tick(2*u);
  endtask

  initial begin
    // 1: reset with the strip idle, then sit idle
    tick(3);
    chk("rst_id", {24'h0, id}, 32'h00);
    chk("rst_vld", {31'h0, vld}, 32'h0);
    rst_n = 1'b1;
    tick(100);
    chk("idle_id", {24'h0, id}, 32'h00);
    chk("idle_vld", {31'h0, vld}, 32'h0);
    chk("idle_vld8", {31'h0, vld8}, 32'h0);

    // 2: frame 2A with exact publish latency on the last bit (a 0, low 750)
    send(1'b0, 8'h2A, 7, 250);
    drv(1'b0, 1'b0);
    tick(503);
    chk("2A_vld_early", {31'h0, vld}, 32'h0);
    tick(1);
    chk("2A_vld", {31'h0, vld}, 32'h1);
    chk("2A_id", {24'h0, id}, 32'h2A);
    tick(246);
    drv(1'b0, 1'b1);
    tick(250);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("2A_clr_vld", {31'h0, vld}, 32'h0);
    chk("2A_clr_id", {24'h0, id}, 32'h2A);

    // 3: upper bits 11 are discarded, then 15 publishes
    frame(1'b0, 8'hC5, 250);
    chk("C5_vld", {31'h0, vld}, 32'h0);
    chk("C5_id", {24'h0, id}, 32'h2A);
    frame(1'b0, 8'h15, 250);
    chk("15_vld", {31'h0, vld}, 32'h1);
    chk("15_id", {24'h0, id}, 32'h15);

    // 4: acknowledge held across the DONE cycle of frame 07
    clr = 1'b1;
    tick(2);
    chk("07_pre_vld", {31'h0, vld}, 32'h0);
    send(1'b0, 8'h07, 7, 250);
    drv(1'b0, 1'b0);
    tick(250);
    drv(1'b0, 1'b1);
    tick(253);
    chk("07_held_vld", {31'h0, vld}, 32'h0);
    tick(1);
    clr = 1'b0;
    chk("07_vld", {31'h0, vld}, 32'h1);
    chk("07_id", {24'h0, id}, 32'h07);
    tick(1);
    chk("07_vld_hold", {31'h0, vld}, 32'h1);
    tick(500);

    // 5: 8-bit timer; abandon the frame after 4 bits, expect timeout
    send(1'b1, 8'h3F, 4, 25);
    tick(300);
    chk("tmo_vld8", {31'h0, vld8}, 32'h0);
    chk("tmo_id8", {24'h0, id8}, 32'h00);
    frame(1'b1, 8'h3F, 25);
    chk("3F_vld8", {31'h0, vld8}, 32'h1);
    chk("3F_id8", {24'h0, id8}, 32'h3F);

    // 6: reset in the middle of a bit drops everything at once
    send(1'b0, 8'hFF, 5, 250);
    drv(1'b0, 1'b0);
    tick(100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_id", {24'h0, id}, 32'h00);
    chk("mid_rst_vld", {31'h0, vld}, 32'h0);
    chk("mid_rst_id8", {24'h0, id8}, 32'h00);
    chk("mid_rst_vld8", {31'h0, vld8}, 32'h0);
    drv(1'b0, 1'b1);
    tick(5);
    rst_n = 1'b1;
    tick(20);
    frame(1'b0, 8'h01, 250);
    chk("01_vld", {31'h0, vld}, 32'h1);
    chk("01_id", {24'h0, id}, 32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
